// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the HOLD/HLDA bus arbiter.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLDREQ,
        GRANT,
        RELEASE,
        GAP
    } arb_state_t;

    localparam int unsigned DEF_NREQ       = 4;
    localparam int unsigned DEF_MAX_TENURE = 64;
    localparam int unsigned DEF_CPU_GAP    = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    logic [W:0] pos;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr_i} + (W + 1)'(i);
            if (pos >= (W + 1)'(N)) begin
                pos = pos - (W + 1)'(N);
            end
            if (!valid_o && req_i[pos[W-1:0]]) begin
                idx_o   = pos[W-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the 8088 local bus between the CPU and NREQ masters via HOLD/HLDA,
// round-robin with bounded tenure and a guaranteed CPU gap after each tenure.
module dma_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned MAX_TENURE = DEF_MAX_TENURE,
    parameter int unsigned CPU_GAP    = DEF_CPU_GAP
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NREQ-1:0]         REQ,
    output logic [NREQ-1:0]         GNT,
    output logic                    HOLD,
    input  logic                    HLDA,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    BUSY,
    output logic                    PROTO_ERR
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned TW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
    localparam int unsigned GW = (CPU_GAP > 0) ? $clog2(CPU_GAP + 1) : 1;
    localparam logic [TW-1:0] TEN_LAST = TW'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);
    localparam logic [GW-1:0] GAP_LOAD = GW'(CPU_GAP);

    arb_state_t      state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            perr_q, perr_d;
    logic [TW-1:0]   tenure_q, tenure_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic [OW-1:0]   pick_idx;
    logic            pick_valid;
    logic [OW-1:0]   next_ptr;
    logic            tenure_hit;

    rr_picker #(
        .N(NREQ),
        .W(OW)
    ) u_picker (
        .req_i  (REQ),
        .ptr_i  (ptr_q),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    assign next_ptr   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign tenure_hit = (MAX_TENURE != 0) && (tenure_q == TEN_LAST);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        perr_d   = 1'b0;
        tenure_d = tenure_q;
        gap_d    = gap_q;

        unique case (state_q)
            IDLE: begin
                if (HLDA) begin
                    perr_d = 1'b1;
                end else if (pick_valid) begin
                    owner_d = pick_idx;
                    hold_d  = 1'b1;
                    state_d = HOLDREQ;
                end
            end
            HOLDREQ: begin
                if (HLDA) begin
                    if (REQ[owner_q]) begin
                        gnt_d          = '0;
                        gnt_d[owner_q] = 1'b1;
                        tenure_d       = '0;
                        state_d        = GRANT;
                    end else begin
                        // Requester gave up before the bus was ours: hand it straight back.
                        hold_d  = 1'b0;
                        state_d = RELEASE;
                    end
                end
            end
            GRANT: begin
                tenure_d = tenure_q + 1'b1;
                if (!HLDA) begin
                    // CPU took the bus back under us; the gap still protects it.
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                    perr_d  = 1'b1;
                    ptr_d   = next_ptr;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (!REQ[owner_q] || tenure_hit) begin
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                    ptr_d   = next_ptr;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!HLDA) begin
                    if (CPU_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d = (gap_q == '0) ? '0 : gap_q - 1'b1;
                if (gap_q <= GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            perr_q   <= 1'b0;
            tenure_q <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            perr_q   <= perr_d;
            tenure_q <= tenure_d;
            gap_q    <= gap_d;
        end
    end

    assign GNT       = gnt_q;
    assign HOLD      = hold_q;
    assign OWNER     = owner_q;
    assign BUSY      = busy_q;
    assign PROTO_ERR = perr_q;

endmodule
